// File: rtl/ptmch_trg_gen_if.sv
// Control/status bundle between a burst requester and the trigger-pulse generator.
// The requester drives the master side; the generator implements the slave side.
interface ptmch_trg_gen_if;
  logic        START;
  logic [2:0]  CMD_SEL;
  logic [15:0] REPEAT;
  logic [7:0]  PLS_WIDTH;
  logic [15:0] PLS_GAP;
  logic        ABORT;
  logic [4:0]  TRG_PLS;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic        ABORTED;
  logic [15:0] SENT_CNT;
  logic [8:0]  PADDR;

  modport master (
    output START, CMD_SEL, REPEAT, PLS_WIDTH, PLS_GAP, ABORT,
    input  TRG_PLS, BUSY, DONE, ERR, ABORTED, SENT_CNT, PADDR
  );

  modport slave (
    input  START, CMD_SEL, REPEAT, PLS_WIDTH, PLS_GAP, ABORT,
    output TRG_PLS, BUSY, DONE, ERR, ABORTED, SENT_CNT, PADDR
  );
endinterface

// File: rtl/ptmch_trg_gen.sv
// Burst trigger-pulse generator for the flash command pattern-match counters.
// Emits REPEAT stretched pulses on one selected TRG_PLS line with floored width/gap.
module ptmch_trg_gen #(
  parameter int unsigned MIN_PW  = 4,
  parameter int unsigned MIN_GAP = 4
) (
  input  logic             CLK100M,
  input  logic             RESET,
  ptmch_trg_gen_if.slave   bus
);

  localparam logic [7:0]  MIN_PW_W  = 8'(MIN_PW);
  localparam logic [15:0] MIN_GAP_W = 16'(MIN_GAP);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    FIN
  } state_t;

  state_t      state;
  logic [2:0]  cmd_q;
  logic [15:0] rep_q;
  logic [7:0]  w_q;
  logic [15:0] g_q;
  logic [15:0] tmr;
  logic        abort_pend;
  logic [4:0]  trg_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        aborted_q;
  logic [15:0] sent_q;

  logic        cfg_ok;
  logic [7:0]  w_eff;
  logic [15:0] g_eff;

  function automatic logic [4:0] onehot(input logic [2:0] c);
    onehot = 5'b00001 << c;
  endfunction

  always_comb begin
    cfg_ok = (bus.CMD_SEL <= 3'd4) && (bus.REPEAT != 16'd0);
    w_eff  = (bus.PLS_WIDTH < MIN_PW_W)  ? MIN_PW_W  : bus.PLS_WIDTH;
    g_eff  = (bus.PLS_GAP   < MIN_GAP_W) ? MIN_GAP_W : bus.PLS_GAP;
  end

  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cmd_q      <= '0;
      rep_q      <= '0;
      w_q        <= '0;
      g_q        <= '0;
      tmr        <= '0;
      abort_pend <= 1'b0;
      trg_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
      sent_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            if (cfg_ok) begin
              cmd_q      <= bus.CMD_SEL;
              rep_q      <= bus.REPEAT;
              w_q        <= w_eff;
              g_q        <= g_eff;
              tmr        <= {8'h00, w_eff} - 16'd1;
              abort_pend <= 1'b0;
              sent_q     <= '0;
              aborted_q  <= 1'b0;
              trg_q      <= onehot(bus.CMD_SEL);
              busy_q     <= 1'b1;
              state      <= HIGH;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        // An abort during the high phase cuts the pulse short and does not count it,
        // but still observes a full gap so the counter sees a clean low period.
        HIGH: begin
          if (bus.ABORT || tmr == 16'd0) begin
            trg_q <= '0;
            tmr   <= g_q - 16'd1;
            state <= LOW;
            if (bus.ABORT) begin
              abort_pend <= 1'b1;
            end else begin
              sent_q <= sent_q + 16'd1;
            end
          end else begin
            tmr <= tmr - 16'd1;
          end
        end

        LOW: begin
          if (bus.ABORT) begin
            abort_pend <= 1'b1;
          end
          if (tmr == 16'd0) begin
            if (!abort_pend && !bus.ABORT && sent_q < rep_q) begin
              trg_q <= onehot(cmd_q);
              tmr   <= {8'h00, w_q} - 16'd1;
              state <= HIGH;
            end else begin
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              aborted_q <= abort_pend | bus.ABORT;
              state     <= FIN;
            end
          end else begin
            tmr <= tmr - 16'd1;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.TRG_PLS  = trg_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.ABORTED  = aborted_q;
  assign bus.SENT_CNT = sent_q;
  assign bus.PADDR    = sent_q[8:0];

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// Self-checking bench for ptmch_trg_gen: arithmetic burst-timeline model, randomized
// configs/aborts, and a rising-edge loopback counter standing in for the pulse counters.
module tb_ptmch_trg_gen;

  logic CLK100M = 1'b0;
  logic RESET;
  always #5 CLK100M = ~CLK100M;

  ptmch_trg_gen_if bus ();

  ptmch_trg_gen #(.MIN_PW(4), .MIN_GAP(4)) dut (
    .CLK100M (CLK100M),
    .RESET   (RESET),
    .bus     (bus)
  );

  int passed = 0;
  int total  = 0;

  // Loopback: count rising edges per trigger line.
  int lb [5];
  logic [4:0] prev_trg;
  always @(posedge CLK100M or posedge RESET) begin
    if (RESET) begin
      prev_trg <= '0;
    end else begin
      for (int i = 0; i < 5; i++)
        if (bus.TRG_PLS[i] && !prev_trg[i]) lb[i] <= lb[i] + 1;
      prev_trg <= bus.TRG_PLS;
    end
  end

  function automatic int lb_sum();
    int s = 0;
    for (int i = 0; i < 5; i++) s += lb[i];
    return s;
  endfunction

  task automatic idle_inputs();
    bus.START     = 1'b0;
    bus.CMD_SEL   = '0;
    bus.REPEAT    = '0;
    bus.PLS_WIDTH = '0;
    bus.PLS_GAP   = '0;
    bus.ABORT     = 1'b0;
  endtask

  // Run one burst and compare every cycle against the timeline model.
  // ka: cycle whose closing edge samples ABORT=1 (0 = none). spur: pulse START while busy.
  task automatic run_burst(input string nm, input int cmd, input int rep, input int pw,
                           input int pg, input int ka, input bit spur);
    int w, g, per, dn, d, sent_exp, sb, base_cmd, base_sum, edges_exp;
    bit ab_eff, ab_high;
    int bad_trg, bad_busy, bad_done, bad_err;
    logic [4:0] oh, e_trg, o_trg;
    logic [15:0] s16;
    logic [8:0] e_paddr;
    w   = (pw < 4) ? 4 : pw;
    g   = (pg < 4) ? 4 : pg;
    per = w + g;
    dn  = 1 + rep * per;
    d   = dn;
    sent_exp = rep;
    ab_eff = 0; ab_high = 0;
    if (ka >= 1 && ka <= dn - 1) begin
      ab_eff = 1;
      if (((ka - 1) % per) < w) begin
        ab_high  = 1;
        d        = ka + g + 1;
        sent_exp = (ka - 1) / per;
      end else begin
        d        = 1 + ((ka - 1) / per + 1) * per;
        sent_exp = (ka - 1) / per + 1;
      end
    end
    sb = spur ? int'($urandom_range(1, d - 1)) : -1;
    oh = 5'b00001 << cmd;
    bad_trg = -1; bad_busy = -1; bad_done = -1; bad_err = -1;
    e_trg = '0; o_trg = '0;

    @(negedge CLK100M);
    base_cmd = lb[cmd];
    base_sum = lb_sum();
    bus.START     = 1'b1;
    bus.CMD_SEL   = 3'(cmd);
    bus.REPEAT    = 16'(rep);
    bus.PLS_WIDTH = 8'(pw);
    bus.PLS_GAP   = 16'(pg);
    @(negedge CLK100M);
    for (int k = 1; k <= d + 3; k++) begin
      logic [4:0] et;
      et = (k < d && ((k - 1) % per) < w && !(ab_high && k > ka)) ? oh : 5'b00000;
      if (bus.TRG_PLS !== et && bad_trg < 0) begin bad_trg = k; e_trg = et; o_trg = bus.TRG_PLS; end
      if (bus.BUSY !== (k < d) && bad_busy < 0) bad_busy = k;
      if (bus.DONE !== (k == d) && bad_done < 0) bad_done = k;
      if (bus.ERR !== 1'b0 && bad_err < 0) bad_err = k;
      // Config inputs wander while busy; START is raised only once, with an invalid config.
      bus.START     = (k == sb);
      bus.CMD_SEL   = (k == sb) ? 3'd7 : 3'($urandom_range(0, 7));
      bus.REPEAT    = (k == sb) ? 16'd0 : 16'($urandom);
      bus.PLS_WIDTH = 8'($urandom);
      bus.PLS_GAP   = 16'($urandom);
      bus.ABORT     = (k == ka);
      @(negedge CLK100M);
    end
    idle_inputs();

    total++;
    if (bad_trg >= 0) $display("FAIL %s trg: cycle %0d got %b want %b", nm, bad_trg, o_trg, e_trg);
    else passed++;
    total++;
    if (bad_busy >= 0) $display("FAIL %s busy: first wrong at cycle %0d, want busy for cycles <%0d", nm, bad_busy, d);
    else passed++;
    total++;
    if (bad_done >= 0) $display("FAIL %s done: first wrong at cycle %0d, want pulse only at %0d", nm, bad_done, d);
    else passed++;
    total++;
    if (bad_err >= 0) $display("FAIL %s err: got 1 at cycle %0d want 0", nm, bad_err);
    else passed++;
    s16 = 16'(sent_exp);
    e_paddr = s16[8:0];
    total++;
    if (bus.SENT_CNT !== s16) $display("FAIL %s sent_cnt: got %0d want %0d", nm, bus.SENT_CNT, s16);
    else passed++;
    total++;
    if (bus.PADDR !== e_paddr) $display("FAIL %s paddr: got %0d want %0d", nm, bus.PADDR, e_paddr);
    else passed++;
    total++;
    if (bus.ABORTED !== ab_eff) $display("FAIL %s aborted: got %b want %b", nm, bus.ABORTED, ab_eff);
    else passed++;
    edges_exp = ab_high ? sent_exp + 1 : sent_exp;
    total++;
    if (lb[cmd] - base_cmd !== edges_exp || lb_sum() - base_sum !== edges_exp)
      $display("FAIL %s loopback: line %0d got %0d (all lines %0d) want %0d", nm, cmd,
               lb[cmd] - base_cmd, lb_sum() - base_sum, edges_exp);
    else passed++;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle_inputs();
    #12;
    total++;
    if ({bus.TRG_PLS, bus.BUSY, bus.DONE, bus.ERR, bus.ABORTED, bus.SENT_CNT, bus.PADDR} !== '0)
      $display("FAIL reset_init: got trg=%b busy=%b done=%b err=%b ab=%b sent=%0d paddr=%0d want all 0",
               bus.TRG_PLS, bus.BUSY, bus.DONE, bus.ERR, bus.ABORTED, bus.SENT_CNT, bus.PADDR);
    else passed++;
    @(negedge CLK100M);
    RESET = 1'b0;
    // Burst on line 2 with a long high phase, then reset in the middle of it.
    bus.START = 1'b1; bus.CMD_SEL = 3'd2; bus.REPEAT = 16'd5; bus.PLS_WIDTH = 8'd10; bus.PLS_GAP = 16'd4;
    @(negedge CLK100M);
    idle_inputs();
    repeat (3) @(negedge CLK100M);
    total++;
    if (bus.TRG_PLS !== 5'b00100) $display("FAIL reset_prehigh: got %b want 00100", bus.TRG_PLS);
    else passed++;
    #1 RESET = 1'b1;
    #1;
    total++;
    if ({bus.TRG_PLS, bus.BUSY, bus.DONE, bus.SENT_CNT, bus.PADDR} !== '0)
      $display("FAIL reset_async: got trg=%b busy=%b done=%b sent=%0d paddr=%0d want all 0",
               bus.TRG_PLS, bus.BUSY, bus.DONE, bus.SENT_CNT, bus.PADDR);
    else passed++;
    @(negedge CLK100M);
    RESET = 1'b0;
    repeat (4) @(negedge CLK100M);
    total++;
    if ({bus.TRG_PLS, bus.BUSY, bus.DONE} !== '0)
      $display("FAIL reset_after: got trg=%b busy=%b done=%b want 0", bus.TRG_PLS, bus.BUSY, bus.DONE);
    else passed++;
  endtask

  task automatic test_err();
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK100M);
      bus.START     = 1'b1;
      bus.CMD_SEL   = (n < 3) ? 3'(5 + n) : 3'($urandom_range(0, 4));
      bus.REPEAT    = (n < 3) ? 16'($urandom_range(1, 9)) : 16'd0;
      bus.PLS_WIDTH = 8'd5;
      bus.PLS_GAP   = 16'd5;
      @(negedge CLK100M);
      idle_inputs();
      total++;
      if ({bus.ERR, bus.BUSY, bus.TRG_PLS} !== 7'b1000000)
        $display("FAIL err_pulse%0d: got err=%b busy=%b trg=%b want err=1 busy=0 trg=0", n, bus.ERR, bus.BUSY, bus.TRG_PLS);
      else passed++;
      @(negedge CLK100M);
      total++;
      if ({bus.ERR, bus.BUSY, bus.TRG_PLS} !== 7'b0000000)
        $display("FAIL err_clear%0d: got err=%b busy=%b trg=%b want 0", n, bus.ERR, bus.BUSY, bus.TRG_PLS);
      else passed++;
    end
  endtask

  task automatic test_basic();      run_burst("basic",   3, 3, 5, 6, 0, 0); endtask
  task automatic test_min_floor();  run_burst("floor",   0, 2, 1, 0, 0, 0); endtask
  task automatic test_abort();
    run_burst("abort_high", int'($urandom_range(0, 4)), 4, 4, 4, 10, 1);
    run_burst("abort_low",  1, 3, 6, 5, 8, 1);
  endtask
  task automatic test_back_to_back();
    run_burst("b2b_a", 2, 2, 7, 4, 0, 1);
    run_burst("b2b_b", 2, 1, 0, 9, 0, 0);
  endtask
  task automatic test_page_wrap();  run_burst("wrap",    4, 600, 4, 4, 0, 0); endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int c, r, pw, pg, w, g, ka;
      c  = int'($urandom_range(0, 4));
      r  = int'($urandom_range(1, 5));
      pw = int'($urandom_range(0, 9));
      pg = int'($urandom_range(0, 9));
      w  = (pw < 4) ? 4 : pw;
      g  = (pg < 4) ? 4 : pg;
      ka = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 1 + r * (w + g) + 1)) : 0;
      run_burst($sformatf("rand%0d", n), c, r, pw, pg, ka, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_floor();
    test_err();
    test_abort();
    test_back_to_back();
    test_page_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
